// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states and
// byte-lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE,
    RD_WAIT
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] mask;
    mask = 4'b0000;
    case (f3)
      F3_B, F3_BU: mask = 4'b0001 << off;
      F3_H, F3_HU: mask = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~off[0];
      F3_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a BRAM word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_offset)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h00_0000, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0000, w_half};
      F3_W:    o_rdata = i_word;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the core LSU and a synchronous BRAM with byte write enables
// and a configurable read latency.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout
);

  localparam logic [2:0] LatCnt = 3'(READ_LATENCY);

  state_t                r_state, w_state_d;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [3:0]            r_mem_we;
  logic [31:0]           r_mem_din;
  logic                  r_err;
  logic [1:0]            r_off;
  logic [2:0]            r_f3;
  logic [31:0]           r_rdata;

  logic        w_accept;
  logic        w_ok;
  logic        w_load_go;
  logic        w_done;
  logic [31:0] w_ld_data;
  logic [31:0] w_din;
  logic        w_unused_addr;

  // Byte address bits above the BRAM window are dropped, so accesses wrap.
  assign w_unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign w_ok      = access_ok(funct3, addr[1:0]);
  assign w_accept  = req && ready;
  assign w_load_go = w_accept && !we && w_ok;
  assign w_done    = (r_state == RD_WAIT) && (r_cnt == 3'd0);

  always_comb begin
    w_din = wdata;
    case (funct3)
      F3_B, F3_BU: w_din = {4{wdata[7:0]}};
      F3_H, F3_HU: w_din = {2{wdata[15:0]}};
      default:     w_din = wdata;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_load_go) w_state_d = RD_WAIT;
      RD_WAIT: if (w_done) w_state_d = w_load_go ? RD_WAIT : IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_mem_addr <= '0;
      r_mem_we   <= 4'b0000;
      r_mem_din  <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_off      <= 2'b00;
      r_f3       <= 3'b000;
      r_rdata    <= 32'h0000_0000;
    end else begin
      r_state  <= w_state_d;
      r_err    <= w_accept && !w_ok;
      r_mem_we <= (w_accept && we && w_ok) ? lane_mask(funct3, addr[1:0]) : 4'b0000;
      if (w_accept && w_ok) begin
        r_mem_addr <= addr[ADDR_WIDTH+1:2];
        r_off      <= addr[1:0];
        r_f3       <= funct3;
      end
      if (w_accept && we && w_ok) r_mem_din <= w_din;
      if (w_load_go) begin
        r_cnt <= LatCnt;
      end else if (r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_done) r_rdata <= w_ld_data;
    end
  end

  load_align u_load_align (
    .i_word   (mem_dout),
    .i_offset (r_off),
    .i_funct3 (r_f3),
    .o_rdata  (w_ld_data)
  );

  // Load data is forwarded combinationally in the pulse cycle, then held.
  assign ready        = (r_state == IDLE) || w_done;
  assign rvalid       = w_done;
  assign rdata        = w_done ? w_ld_data : r_rdata;
  assign misalign_err = r_err;
  assign mem_addr     = r_mem_addr;
  assign mem_we       = r_mem_we;
  assign mem_din      = r_mem_din;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with READ_LATENCY=1 and READ_LATENCY=3 instances,
// each backed by a small write-first BRAM model.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic clk;
  logic rstn;

  logic        req1, we1, ready1, rvalid1, err1;
  logic [2:0]  f3_1;
  logic [31:0] addr1, wdata1, rdata1, mdin1, mdout1;
  logic [19:0] maddr1;
  logic [3:0]  mwe1;

  logic        req3, we3, ready3, rvalid3, err3;
  logic [2:0]  f3_3;
  logic [31:0] addr3, wdata3, rdata3, mdin3, mdout3;
  logic [19:0] maddr3;
  logic [3:0]  mwe3;

  int checks;
  int failures;

  data_mem_ctrl #(.ADDR_WIDTH(20), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .req(req1), .we(we1), .funct3(f3_1), .addr(addr1),
    .wdata(wdata1), .ready(ready1), .rvalid(rvalid1), .rdata(rdata1),
    .misalign_err(err1), .mem_addr(maddr1), .mem_we(mwe1), .mem_din(mdin1),
    .mem_dout(mdout1)
  );

  data_mem_ctrl #(.ADDR_WIDTH(20), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .req(req3), .we(we3), .funct3(f3_3), .addr(addr3),
    .wdata(wdata3), .ready(ready3), .rvalid(rvalid3), .rdata(rdata3),
    .misalign_err(err3), .mem_addr(maddr3), .mem_we(mwe3), .mem_din(mdin3),
    .mem_dout(mdout3)
  );

  // BRAM models: per-byte write enables, write-first read, latency 1 and 3.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] merged1, merged3, pipe1;
  logic [31:0] pipe3 [3];

  always_comb begin
    merged1 = mem1[maddr1[7:0]];
    for (int i = 0; i < 4; i++) if (mwe1[i]) merged1[8*i +: 8] = mdin1[8*i +: 8];
    merged3 = mem3[maddr3[7:0]];
    for (int i = 0; i < 4; i++) if (mwe3[i]) merged3[8*i +: 8] = mdin3[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (|mwe1) mem1[maddr1[7:0]] <= merged1;
    pipe1 <= merged1;
    if (|mwe3) mem3[maddr3[7:0]] <= merged3;
    pipe3[0] <= merged3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mdout1 = pipe1;
  assign mdout3 = pipe3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_we;
    logic [19:0] exp_maddr;
    logic [31:0] exp_din;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NumVec = 19;
  vec_t vecs [NumVec];

  // One access on the latency-1 instance; returns sampled #1 after the last edge.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    req1 = 1'b1; we1 = v.we; f3_1 = v.f3; addr1 = v.addr; wdata1 = v.wdata;
    check("ready_before_accept", idx, {31'd0, ready1}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    check("mem_we", idx, {28'd0, mwe1}, {28'd0, v.exp_we});
    check("misalign_err", idx, {31'd0, err1}, {31'd0, v.exp_err});
    check("rvalid_a1", idx, {31'd0, rvalid1}, 32'd0);
    if (!v.exp_err) check("mem_addr", idx, {12'd0, maddr1}, {12'd0, v.exp_maddr});
    if (v.we && !v.exp_err) check("mem_din", idx, mdin1, v.exp_din);
    if (v.exp_err || v.we) begin
      check("ready_a1", idx, {31'd0, ready1}, 32'd1);
    end else begin
      check("ready_a1", idx, {31'd0, ready1}, 32'd0);
      @(posedge clk); #1;
      check("rvalid_a2", idx, {31'd0, rvalid1}, 32'd1);
      check("rdata_a2", idx, rdata1, v.exp_rdata);
      check("ready_a2", idx, {31'd0, ready1}, 32'd1);
    end
    if (v.exp_err) begin
      @(posedge clk); #1;
      check("misalign_pulse_end", idx, {31'd0, err1}, 32'd0);
      check("rvalid_after_err", idx, {31'd0, rvalid1}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    req1 = 1'b0; we1 = 1'b0; f3_1 = F3_W; addr1 = '0; wdata1 = '0;
    req3 = 1'b0; we3 = 1'b0; f3_3 = F3_W; addr3 = '0; wdata3 = '0;

    //          we    f3     addr           wdata          we      maddr     din           err   rdata
    vecs[0]  = '{1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 20'h00040, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, F3_W,  32'h0000_0100, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, F3_B,  32'h0000_0101, 32'h0000_00AA, 4'b0010, 20'h00040, 32'hAAAA_AAAA, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, F3_B,  32'h0000_0101, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'hFFFF_FFAA};
    vecs[4]  = '{1'b0, F3_BU, 32'h0000_0101, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'h0000_00AA};
    vecs[5]  = '{1'b1, F3_H,  32'h0000_0102, 32'h0000_8001, 4'b1100, 20'h00040, 32'h8001_8001, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, F3_H,  32'h0000_0102, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'hFFFF_8001};
    vecs[7]  = '{1'b0, F3_HU, 32'h0000_0102, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'h0000_8001};
    vecs[8]  = '{1'b0, F3_W,  32'h0000_0103, 32'h0,         4'b0000, 20'h00000, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b0, F3_H,  32'h0000_0101, 32'h0,         4'b0000, 20'h00000, 32'h0,         1'b1, 32'h0};
    vecs[10] = '{1'b1, 3'b011, 32'h0000_0100, 32'h1234_5678, 4'b0000, 20'h00000, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, F3_W,  32'h0000_0100, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'h8001_AAEF};
    vecs[12] = '{1'b1, F3_B,  32'h0000_0203, 32'h1234_5680, 4'b1000, 20'h00080, 32'h8080_8080, 1'b0, 32'h0};
    vecs[13] = '{1'b0, F3_B,  32'h0000_0203, 32'h0,         4'b0000, 20'h00080, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[14] = '{1'b1, F3_W,  32'h0040_0100, 32'h1122_3344, 4'b1111, 20'h00040, 32'h1122_3344, 1'b0, 32'h0};
    vecs[15] = '{1'b0, F3_B,  32'h0000_0100, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'h0000_0044};
    vecs[16] = '{1'b1, F3_H,  32'h0000_0100, 32'hFFFF_7FFE, 4'b0011, 20'h00040, 32'h7FFE_7FFE, 1'b0, 32'h0};
    vecs[17] = '{1'b0, F3_HU, 32'h0000_0102, 32'h0,         4'b0000, 20'h00040, 32'h0,         1'b0, 32'h0000_1122};
    vecs[18] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,        4'b0000, 20'h00000, 32'h0,         1'b1, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready1", 0, {31'd0, ready1}, 32'd1);
    check("rst_rvalid1", 0, {31'd0, rvalid1}, 32'd0);
    check("rst_rdata1", 0, rdata1, 32'd0);
    check("rst_err1", 0, {31'd0, err1}, 32'd0);
    check("rst_mem_we1", 0, {28'd0, mwe1}, 32'd0);
    check("rst_mem_addr1", 0, {12'd0, maddr1}, 32'd0);
    check("rst_mem_din1", 0, mdin1, 32'd0);
    check("rst_ready3", 0, {31'd0, ready3}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < NumVec; i++) run_vec(vecs[i], i);

    // Back-to-back stores, then a load of the same word on the very next accept.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; f3_1 = F3_B; addr1 = 32'h0000_0300; wdata1 = 32'h0000_0011;
    @(posedge clk); #1;
    check("b2b_we0", 0, {28'd0, mwe1}, 32'h1);
    check("b2b_din0", 0, mdin1, 32'h1111_1111);
    check("b2b_ready0", 0, {31'd0, ready1}, 32'd1);
    addr1 = 32'h0000_0301; wdata1 = 32'h0000_0022;
    @(posedge clk); #1;
    check("b2b_we1", 1, {28'd0, mwe1}, 32'h2);
    check("b2b_din1", 1, mdin1, 32'h2222_2222);
    we1 = 1'b0; f3_1 = F3_HU; addr1 = 32'h0000_0300;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("stl_we", 0, {28'd0, mwe1}, 32'h0);
    check("stl_ready", 0, {31'd0, ready1}, 32'd0);
    @(posedge clk); #1;
    check("stl_rvalid", 0, {31'd0, rvalid1}, 32'd1);
    check("stl_rdata", 0, rdata1, 32'h0000_2211);
    @(posedge clk); #1;
    check("hold_rvalid", 0, {31'd0, rvalid1}, 32'd0);
    check("hold_rdata", 0, rdata1, 32'h0000_2211);

    // Latency-3 instance: held req is ignored while ready=0 and only sampled on accept.
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; f3_3 = F3_W; addr3 = 32'h0000_0100; wdata3 = 32'hCAFE_F00D;
    @(negedge clk);
    addr3 = 32'h0000_0104; wdata3 = 32'h0BAD_BEEF;
    @(negedge clk);
    we3 = 1'b0; addr3 = 32'h0000_0100;
    @(posedge clk); #1;
    check("l3_ready", 1, {31'd0, ready3}, 32'd0);
    check("l3_rvalid", 1, {31'd0, rvalid3}, 32'd0);
    @(negedge clk);
    addr3 = 32'h0000_0104;
    for (int k = 2; k <= 3; k++) begin
      @(posedge clk); #1;
      check("l3_ready", k, {31'd0, ready3}, 32'd0);
      check("l3_rvalid", k, {31'd0, rvalid3}, 32'd0);
    end
    @(posedge clk); #1;
    check("l3_ready", 4, {31'd0, ready3}, 32'd1);
    check("l3_rvalid", 4, {31'd0, rvalid3}, 32'd1);
    check("l3_rdata", 4, rdata3, 32'hCAFE_F00D);
    @(posedge clk); #1;
    req3 = 1'b0;
    check("l3b_ready", 1, {31'd0, ready3}, 32'd0);
    check("l3b_rvalid", 1, {31'd0, rvalid3}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("l3b_rvalid", 4, {31'd0, rvalid3}, 32'd1);
    check("l3b_rdata", 4, rdata3, 32'h0BAD_BEEF);
    @(posedge clk); #1;
    check("l3b_rvalid", 5, {31'd0, rvalid3}, 32'd0);

    // Reset during a pending load drops it.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; f3_1 = F3_W; addr1 = 32'h0000_0100;
    @(posedge clk); #1;
    req1 = 1'b0;
    check("rl_ready_a1", 0, {31'd0, ready1}, 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rl_ready", 0, {31'd0, ready1}, 32'd1);
    check("rl_rvalid", 0, {31'd0, rvalid1}, 32'd0);
    check("rl_rdata", 0, rdata1, 32'd0);
    check("rl_mem_addr", 0, {12'd0, maddr1}, 32'd0);
    check("rl_mem_we", 0, {28'd0, mwe1}, 32'd0);
    check("rl_mem_din", 0, mdin1, 32'd0);
    check("rl_err", 0, {31'd0, err1}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rl_no_rvalid", k, {31'd0, rvalid1}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
